// File: rtl/rfe_pkg.sv
// rfe_pkg: shared FSM encoding and RM(1,M) size helpers for the RFE stream blocks
package rfe_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUF_WAIT,
    S_TRNG_WAIT,
    S_OUT,
    S_DONE
  } rfe_state_e;

  function automatic int rfe_n(input int m);
    return 1 << m;
  endfunction

  function automatic int rfe_k(input int m);
    return m + 1;
  endfunction

endpackage

// File: rtl/rm1_encoder.sv
// rm1_encoder: combinational RM(1,M) encoder, cw[u] = x[0] ^ parity(x[M:1] & u)
module rm1_encoder import rfe_pkg::*; #(
  parameter int M = 5
) (
  input  logic [rfe_k(M)-1:0] x_i,
  output logic [rfe_n(M)-1:0] cw_o
);

  for (genvar u = 0; u < rfe_n(M); u++) begin : g_bit
    localparam logic [M-1:0] UB = M'(u);
    assign cw_o[u] = x_i[0] ^ (^(x_i[M:1] & UB));
  end

endmodule

// File: rtl/rfe_stream_gen.sv
// rfe_stream_gen: block-serial helper-data generator, H_b = R'_b ^ RM(1,M)(x_b), valid/ready output.
// Optional R'_b output port enabled by defining RFE_RPRIME_OUT_EN.
module rfe_stream_gen import rfe_pkg::*; #(
  parameter int M          = 5,
  parameter int BLOCKS     = 22,
  parameter int PUF_BLOCKS = 2,
  parameter int IDX_W      = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               abort,
  output logic                               busy,
  output logic                               done,
  output logic                               puf_req,
  input  logic                               puf_valid,
  input  logic [PUF_BLOCKS*rfe_n(M)-1:0]     puf_data,
  output logic                               trng_req,
  input  logic                               trng_valid,
  input  logic [rfe_k(M)-1:0]                trng_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [rfe_n(M)-1:0]                out_helper,
  output logic [IDX_W-1:0]                   out_idx,
  output logic                               out_last
`ifdef RFE_RPRIME_OUT_EN
  ,
  output logic [rfe_n(M)-1:0]                out_rprime
`endif
);

  localparam int N  = rfe_n(M);
  localparam int PW = PUF_BLOCKS > 1 ? $clog2(PUF_BLOCKS) : 1;

  rfe_state_e              state_q, state_d;
  logic                    start_q;
  logic [IDX_W-1:0]        blk_q, blk_d;
  logic [PW-1:0]           pidx_q, pidx_d;
  logic [PUF_BLOCKS*N-1:0] puf_q, puf_d;
  logic [N-1:0]            helper_q, helper_d;
  logic [N-1:0]            cw, rword;
  logic                    last;
`ifdef RFE_RPRIME_OUT_EN
  logic [N-1:0]            rprime_q, rprime_d;
`endif

  rm1_encoder #(.M(M)) u_enc (
    .x_i  (trng_data),
    .cw_o (cw)
  );

  assign rword      = puf_q[int'(pidx_q)*N +: N];
  assign last       = blk_q == IDX_W'(BLOCKS - 1);
  assign busy       = state_q inside {S_PUF_WAIT, S_TRNG_WAIT, S_OUT};
  assign done       = state_q == S_DONE;
  assign puf_req    = state_q == S_PUF_WAIT;
  assign trng_req   = state_q == S_TRNG_WAIT;
  assign out_valid  = state_q == S_OUT;
  assign out_last   = out_valid && last;
  assign out_helper = helper_q;
  assign out_idx    = blk_q;
`ifdef RFE_RPRIME_OUT_EN
  assign out_rprime = rprime_q;
`endif

  // next-state: abort from any active state beats every other event
  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    pidx_d   = pidx_q;
    puf_d    = puf_q;
    helper_d = helper_q;
`ifdef RFE_RPRIME_OUT_EN
    rprime_d = rprime_q;
`endif
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (start && !start_q) begin
          state_d = S_PUF_WAIT;
          blk_d   = '0;
          pidx_d  = '0;
        end
        S_PUF_WAIT: if (puf_valid) begin
          puf_d   = puf_data;
          state_d = S_TRNG_WAIT;
        end
        S_TRNG_WAIT: if (trng_valid) begin
          helper_d = rword ^ cw;
`ifdef RFE_RPRIME_OUT_EN
          rprime_d = rword;
`endif
          state_d  = S_OUT;
        end
        S_OUT: if (out_ready) begin
          state_d = last ? S_DONE : S_TRNG_WAIT;
          blk_d   = last ? blk_q : blk_q + IDX_W'(1);
          pidx_d  = last ? pidx_q : (pidx_q == PW'(PUF_BLOCKS - 1) ? '0 : pidx_q + PW'(1));
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // state, counters and data latches with async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      blk_q    <= '0;
      pidx_q   <= '0;
      puf_q    <= '0;
      helper_q <= '0;
`ifdef RFE_RPRIME_OUT_EN
      rprime_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      blk_q    <= blk_d;
      pidx_q   <= pidx_d;
      puf_q    <= puf_d;
      helper_q <= helper_d;
`ifdef RFE_RPRIME_OUT_EN
      rprime_q <= rprime_d;
`endif
    end
  end

endmodule
